nn_ram_arbiter: RTL
===================

Name: nn_ram_arbiter

Overview:
Shares the single-port SoC RAM of nnRvSoc between three requesters: instruction fetch (IF), CPU load/store (LS) and the VGA scan-out reader (VGA). Presents one req/gnt/rvalid handshake per requester and drives one synchronous RAM port with 1-cycle read latency. VGA has priority, bounded by an anti-starvation run limit. IF and LS share the remaining slots round-robin.

Parameters:
AW, 16, word address width of every requester and of the RAM port
VGA_MAX_RUN, 4, maximum consecutive VGA grants while a CPU request is pending (range 1..255)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST_N  in  1  reset, synchronous, active-low
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  AW  IF word address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  rdata valid for IF
ls_req  in  1  LS request; held with ls_we/ls_be/ls_addr/ls_wdata until ls_gnt
ls_we  in  1  1=write, 0=read
ls_be  in  4  byte enables for writes
ls_addr  in  AW  LS word address
ls_wdata  in  32  LS write data
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  rdata valid for LS (reads only)
vga_req  in  1  VGA read request
vga_addr  in  AW  VGA word address
vga_gnt  out  1  VGA request accepted this cycle
vga_rvalid  out  1  rdata valid for VGA
rdata  out  32  read data broadcast to all requesters; qualified by *_rvalid
mem_en  out  1  RAM access enable
mem_we  out  4  RAM byte write enables
mem_addr  out  AW  RAM address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Grant is combinational in the request cycle. At most one *_gnt high per cycle. mem_en = OR of grants. mem_addr/mem_wdata/mem_we are muxed from the granted requester.
- mem_we = ls_be only when ls_gnt&ls_we; otherwise 0.
- Read latency: a read granted in cycle N gives the owner's *_rvalid=1 and rdata=mem_rdata in cycle N+1, for exactly one cycle. LS writes produce no rvalid.
- Registers:
  - owner (NONE/IF/LS/VGA): the read owner for the next cycle.
  - last_cpu (IF/LS).
  - vga_run (8-bit).
- Arbitration each cycle, in order:
  1. vga_req && !(cpu_pend && vga_run==VGA_MAX_RUN) -> VGA. cpu_pend = if_req|ls_req.
  2. if_req && ls_req -> the one not equal to last_cpu.
  3. Otherwise, the single pending CPU requester.
- Register updates:
  - last_cpu updates to the granted CPU requester on every CPU grant.
  - vga_run increments on a VGA grant, saturating at VGA_MAX_RUN.
  - vga_run clears to 0 on any cycle without a VGA grant.
- Requests may be held across many cycles. Inputs are sampled only in the grant cycle. A request withdrawn before its grant is legal and is dropped.
- Back-to-back grants are allowed every cycle. A new grant in N+1 overlaps rvalid for the grant issued in N.
- Reset (RST_N low at a rising edge):
  - owner=NONE, last_cpu=LS (so IF wins the first tie), vga_run=0.
  - All *_gnt, mem_en and mem_we are forced 0 combinationally while RST_N=0.
  - All *_rvalid are 0 in the cycle after a reset edge; a read granted before reset returns no rvalid.
  - rdata is a pass-through of mem_rdata, don't-care while all rvalid are 0.
- Simultaneous events:
  - All three requesting with vga_run<VGA_MAX_RUN -> VGA wins.
  - All three requesting at the run limit -> CPU round-robin winner; vga_run then clears.
- VGA alone (no CPU request) may be granted indefinitely; vga_run stays saturated without blocking.

Optional Feature:
NN_ARB_PERF_EN
- Defined:
  - Adds outputs perf_if_stall, perf_ls_stall, perf_vga_stall (32 bits each). Each counts cycles with req=1 and gnt=0 for that requester.
  - Wraps at 2^32, cleared by reset.
  - Adds input perf_clr; perf_clr=1 clears all three counters at the next edge, overriding an increment in the same cycle.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset, then IF read addr 0x0010 with RAM[0x10]=0xDEADBEEF -> if_gnt in cycle N, if_rvalid=1 and rdata=0xDEADBEEF in N+1, ls/vga rvalid=0.
- LS write addr 0x0020, be=4'b0011, wdata=0x12345678 -> mem_we=4'b0011 for one cycle. A later LS read of 0x0020 returns the low half 0x5678, and ls_rvalid never pulses for the write.
- IF and LS requesting continuously from reset -> grants alternate IF,LS,IF,LS, and each rvalid trails its grant by exactly one cycle.
- VGA, IF and LS all continuously requesting, VGA_MAX_RUN=4 -> pattern VGA×4, IF, VGA×4, LS, repeating.
- RST_N low in the cycle after an IF grant -> if_rvalid=0 in that cycle. In the first post-reset cycle, with IF and LS both requesting, IF wins.
- With NN_ARB_PERF_EN: IF blocked 10 cycles by VGA -> perf_if_stall=10. Assert perf_clr -> next cycle 0.

Source files
------------

// File: rtl/nn_ram_arbiter.sv
// Three-way arbiter in front of the single-port nnRvSoc RAM: VGA first, limited by a run counter, then IF/LS round-robin.
// Optional stall counters are compiled in with `define NN_ARB_PERF_EN.
module nn_ram_arbiter #(
    parameter int AW          = 16,
    parameter int VGA_MAX_RUN = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [3:0]    ls_be,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
`ifdef NN_ARB_PERF_EN
    ,
    input  logic          perf_clr,
    output logic [31:0]   perf_if_stall,
    output logic [31:0]   perf_ls_stall,
    output logic [31:0]   perf_vga_stall
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_VGA} owner_e;
    typedef enum logic {CPU_IF, CPU_LS} cpu_e;

    localparam logic [7:0] RUN_MAX = 8'(VGA_MAX_RUN);

    owner_e     owner_q, owner_d;
    cpu_e       lastCpu_q, lastCpu_d;
    logic [7:0] vgaRun_q, vgaRun_d;

    logic cpuPend;
    logic vgaWin;
    logic ifGnt, lsGnt, vgaGnt;

    // VGA loses its priority only once it has used up its run while a CPU request waits.
    always_comb begin
        ifGnt   = 1'b0;
        lsGnt   = 1'b0;
        vgaGnt  = 1'b0;
        cpuPend = if_req | ls_req;
        vgaWin  = vga_req && !(cpuPend && (vgaRun_q == RUN_MAX));
        if (RST_N) begin
            if (vgaWin) begin
                vgaGnt = 1'b1;
            end else if (if_req && ls_req) begin
                if (lastCpu_q == CPU_LS) ifGnt = 1'b1;
                else                     lsGnt = 1'b1;
            end else if (if_req) begin
                ifGnt = 1'b1;
            end else if (ls_req) begin
                lsGnt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            owner_q   <= OWN_NONE;
            lastCpu_q <= CPU_LS;
            vgaRun_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            lastCpu_q <= lastCpu_d;
            vgaRun_q  <= vgaRun_d;
        end
    end

    always_comb begin
        owner_d   = OWN_NONE;
        lastCpu_d = lastCpu_q;
        vgaRun_d  = '0;
        if (vgaGnt)               owner_d = OWN_VGA;
        else if (ifGnt)           owner_d = OWN_IF;
        else if (lsGnt && !ls_we) owner_d = OWN_LS;
        if (ifGnt) lastCpu_d = CPU_IF;
        if (lsGnt) lastCpu_d = CPU_LS;
        if (vgaGnt) vgaRun_d = (vgaRun_q == RUN_MAX) ? RUN_MAX : vgaRun_q + 8'd1;
    end

    // rvalid is also gated by RST_N so a read granted just before reset never returns.
    always_comb begin
        if_gnt     = ifGnt;
        ls_gnt     = lsGnt;
        vga_gnt    = vgaGnt;
        if_rvalid  = RST_N && (owner_q == OWN_IF);
        ls_rvalid  = RST_N && (owner_q == OWN_LS);
        vga_rvalid = RST_N && (owner_q == OWN_VGA);
        mem_en     = ifGnt | lsGnt | vgaGnt;
        mem_we     = (lsGnt && ls_we) ? ls_be : 4'b0000;
        mem_wdata  = lsGnt ? ls_wdata : 32'h0;
        mem_addr   = '0;
        if (vgaGnt)     mem_addr = vga_addr;
        else if (ifGnt) mem_addr = if_addr;
        else if (lsGnt) mem_addr = ls_addr;
        rdata      = mem_rdata;
    end

`ifdef NN_ARB_PERF_EN
    logic [31:0] ifStall_q, lsStall_q, vgaStall_q;

    always_ff @(posedge CLK) begin
        if (!RST_N || perf_clr) begin
            ifStall_q  <= '0;
            lsStall_q  <= '0;
            vgaStall_q <= '0;
        end else begin
            if (if_req && !ifGnt)   ifStall_q  <= ifStall_q + 32'd1;
            if (ls_req && !lsGnt)   lsStall_q  <= lsStall_q + 32'd1;
            if (vga_req && !vgaGnt) vgaStall_q <= vgaStall_q + 32'd1;
        end
    end

    assign perf_if_stall  = ifStall_q;
    assign perf_ls_stall  = lsStall_q;
    assign perf_vga_stall = vgaStall_q;
`endif

endmodule
